// File: rtl/channel_readout_arbiter.sv
// rtl/channel_readout_arbiter.sv - round-robin burst readout of four channel FIFOs into one tagged stream
//
// Grants one channel at a time (round robin, channel 0 first after reset) and
// pulls up to BURST_LEN 120-bit words from it. The words are merged into a
// two-entry output buffer that drives a ready/valid stream tagged with the
// source channel and a start-of-burst flag. The block also sequences FIFO
// flushes: stop guard, synchronous FIFO reset pulse, stop guard, done pulse.
//
// Optional build macro READOUT_HEADER_EN: each burst is preceded by one header
// word {8'hA5, channel, planned length, 100'b0} that carries the sob flag.
//
// Ports:
//   clk160               readout clock
//   reset                asynchronous active-high reset
//   enable[3:0]          per-channel readout enable, sampled only while idle
//   flush_req            single-cycle flush request for all four FIFOs
//   channel_fifo_empty   FIFO empty flags, bit i = channel i
//   channel_data_counter FIFO word counts, channel i = [10i+9:10i]
//   channel_data         FIFO read data, channel i = [120i+119:120i], valid one cycle after the read
//   channel_data_read    one-hot FIFO read strobe
//   channel_fifo_s_reset FIFO synchronous reset, all bits together
//   data_tran_stop       halts decoder writes, all bits together
//   out_data/out_valid/out_ready/out_channel/out_sob  merged output stream
//   busy                 FSM is not idle
//   flush_done           one-cycle pulse at the end of a flush
module channel_readout_arbiter #(
  parameter int BURST_LEN    = 16,
  parameter int FLUSH_CYCLES = 8,
  parameter int STOP_GUARD   = 4
) (
  input  logic         clk160,
  input  logic         reset,
  input  logic [3:0]   enable,
  input  logic         flush_req,
  input  logic [3:0]   channel_fifo_empty,
  input  logic [39:0]  channel_data_counter,
  input  logic [479:0] channel_data,
  output logic [3:0]   channel_data_read,
  output logic [3:0]   channel_fifo_s_reset,
  output logic [3:0]   data_tran_stop,
  output logic [119:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_channel,
  output logic         out_sob,
  output logic         busy,
  output logic         flush_done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GRANT,
`ifdef READOUT_HEADER_EN
    S_HDR,
`endif
    S_READ,
    S_DRAIN,
    S_FPRE,
    S_FRST,
    S_FPOST,
    S_FDONE
  } state_t;

  localparam logic [9:0] BURST_MAX = 10'(BURST_LEN);

  state_t       state, state_nx;
  logic [15:0]  fcnt, fcnt_nx;
  logic [1:0]   rr_ptr, gnt, pick;
  logic         found;
  logic [9:0]   remain;
  logic         first_word;
  logic         inflight;
  logic         flush_pending;

  logic [9:0]   cnt_arr [4];
  logic [119:0] dat_arr [4];
  logic [3:0]   eligible;

  logic         space_ok, rd_en, pop, wr_en, hdr_push, wr_sob;
  logic [119:0] wr_data;

  logic [119:0] buf_data [2];
  logic [1:0]   buf_ch   [2];
  logic         buf_sob  [2];
  logic         wptr, rptr;
  logic [1:0]   buf_count;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_arr[i] = channel_data_counter[i*10 +: 10];
      dat_arr[i] = channel_data[i*120 +: 120];
    end
  end

  assign eligible = enable & ~channel_fifo_empty;

  // Search rr_ptr+1, rr_ptr+2, ... so the last granted channel comes last.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    for (int k = 1; k <= 4; k++) begin
      if (!found && eligible[rr_ptr + 2'(k)]) begin
        found = 1'b1;
        pick  = rr_ptr + 2'(k);
      end
    end
  end

  // A word already requested but not yet written still needs a buffer slot;
  // a pop in this cycle frees one, which keeps a 1 word/cycle stream going.
  assign pop      = out_valid & out_ready;
  assign space_ok = (3'(buf_count) + 3'(inflight)) < (3'd2 + 3'(pop));

  // Combinational from registered state, so reset removes the strobe at once.
  assign rd_en = (state == S_READ) && (remain != 10'd0) &&
                 !channel_fifo_empty[gnt] && space_ok;
  assign channel_data_read = rd_en ? (4'b0001 << gnt) : 4'b0000;

`ifdef READOUT_HEADER_EN
  assign hdr_push = (state == S_HDR) && space_ok;
  assign wr_data  = inflight ? dat_arr[gnt] : {8'hA5, gnt, remain, 100'd0};
  assign wr_sob   = inflight ? first_word : 1'b1;
`else
  assign hdr_push = 1'b0;
  assign wr_data  = dat_arr[gnt];
  assign wr_sob   = first_word;
`endif
  // Header pushes and returning data never coincide: no read precedes HDR.
  assign wr_en = inflight | hdr_push;

  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_ch[0]   <= '0;
      buf_ch[1]   <= '0;
      buf_sob[0]  <= 1'b0;
      buf_sob[1]  <= 1'b0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      buf_count   <= 2'd0;
    end else begin
      if (wr_en) begin
        buf_data[wptr] <= wr_data;
        buf_ch[wptr]   <= gnt;
        buf_sob[wptr]  <= wr_sob;
        wptr           <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      buf_count <= buf_count + 2'(wr_en) - 2'(pop);
    end
  end

  assign out_valid   = (buf_count != 2'd0);
  assign out_data    = buf_data[rptr];
  assign out_channel = buf_ch[rptr];
  assign out_sob     = buf_sob[rptr];

  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      fcnt  <= 16'd0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
    end
  end

  always_comb begin
    state_nx             = state;
    fcnt_nx              = fcnt;
    busy                 = (state != S_IDLE);
    data_tran_stop       = 4'b0000;
    channel_fifo_s_reset = 4'b0000;
    flush_done           = 1'b0;
    case (state)
      S_IDLE: begin
        if (flush_pending) begin
          state_nx = S_FPRE;
          fcnt_nx  = 16'(STOP_GUARD - 1);
        end else if (found) begin
          state_nx = S_GRANT;
        end
      end
      S_GRANT: begin
`ifdef READOUT_HEADER_EN
        state_nx = S_HDR;
`else
        state_nx = S_READ;
`endif
      end
`ifdef READOUT_HEADER_EN
      S_HDR: begin
        if (space_ok) state_nx = S_READ;
      end
`endif
      S_READ: begin
        if (remain == 10'd0 || channel_fifo_empty[gnt]) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!inflight) state_nx = S_IDLE;
      end
      S_FPRE: begin
        data_tran_stop = 4'b1111;
        if (fcnt == 16'd0) begin
          state_nx = S_FRST;
          fcnt_nx  = 16'(FLUSH_CYCLES - 1);
        end else begin
          fcnt_nx = fcnt - 16'd1;
        end
      end
      S_FRST: begin
        data_tran_stop       = 4'b1111;
        channel_fifo_s_reset = 4'b1111;
        if (fcnt == 16'd0) begin
          state_nx = S_FPOST;
          fcnt_nx  = 16'(STOP_GUARD - 1);
        end else begin
          fcnt_nx = fcnt - 16'd1;
        end
      end
      S_FPOST: begin
        data_tran_stop = 4'b1111;
        if (fcnt == 16'd0) begin
          state_nx = S_FDONE;
        end else begin
          fcnt_nx = fcnt - 16'd1;
        end
      end
      S_FDONE: begin
        flush_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) begin
      rr_ptr        <= 2'd3;
      gnt           <= 2'd0;
      remain        <= 10'd0;
      first_word    <= 1'b0;
      inflight      <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      inflight <= rd_en;
      // A request arriving in the done cycle is kept and starts a new flush.
      flush_pending <= flush_req | (flush_pending & (state != S_FDONE));
      if (state == S_IDLE && !flush_pending && found) begin
        gnt <= pick;
      end
      if (state == S_GRANT) begin
        rr_ptr <= gnt;
        if (cnt_arr[gnt] == 10'd0) begin
          remain <= 10'd1;
        end else if (cnt_arr[gnt] > BURST_MAX) begin
          remain <= BURST_MAX;
        end else begin
          remain <= cnt_arr[gnt];
        end
`ifdef READOUT_HEADER_EN
        first_word <= 1'b0;
`else
        first_word <= 1'b1;
`endif
      end else if (rd_en) begin
        remain <= remain - 10'd1;
      end
      if (inflight) begin
        first_word <= 1'b0;
      end
    end
  end

endmodule
